wb_regfile_scoreboard: RTL and testbench
========================================

// Module: wb_regfile_scoreboard
// PURPOSE
// - Writeback-side consumer of the 38-bit EX/WB pipeline bundle.
// - Decodes the bundle and commits the ALU result into a 32-entry register bank.
// - Provides two combinational read ports, with same-cycle write-through bypass.
// - Keeps a per-register pending scoreboard. Issue sets an entry; writeback clears it.
// - Produces the stall / LD control that gates the upstream pipeline registers.
// PARAMETERS
// - DATA_W  32  register/data width
// - ADDR_W  5   register index width (2**ADDR_W registers)
// - BUND_W  38  bundle width; must equal 1+ADDR_W+DATA_W
// - CNT_W   16  width of the retired-write counter
// PORTS
// - clk         in   1       rising-edge clock
// - reset       in   1       synchronous, active-low
// - wb_bundle   in   BUND_W  [37]=wb_we, [36:32]=wb_rd, [31:0]=wb_data
// - rs_addr     in   ADDR_W  read port A index
// - rt_addr     in   ADDR_W  read port B index
// - rs_data     out  DATA_W  read port A data (combinational)
// - rt_data     out  DATA_W  read port B data (combinational)
// - iss_valid   in   1       an instruction is presented for issue this cycle
// - iss_we      in   1       issuing instruction writes a destination
// - iss_rd      in   ADDR_W  destination of issuing instruction
// - stall       out  1       issue blocked; upstream registers hold
// - pipe_ld     out  1       ~stall; drives LD of the upstream pipeline registers
// - pending     out  2**ADDR_W  scoreboard bit vector (debug/visibility)
// - wb_count    out  CNT_W   count of committed writes
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - all registers, pending and wb_count clear to 0.
//   - Outputs then read 0: stall=0, pipe_ld=1.
//   - Reset wins over every simultaneous write or issue.
// - Commit:
//   - wb_we=1 and wb_rd!=0 writes wb_data to reg[wb_rd] at the posedge.
//   - The same edge clears pending[wb_rd] and increments wb_count.
//   - wb_count wraps from 2**CNT_W-1 to 0.
//   - wb_we=1 with wb_rd==0: no write, no count, no pending change.
// - Read:
//   - Address 0 always returns 0.
//   - If wb_we && wb_rd==addr && addr!=0, the port returns wb_data (bypass, 0-cycle latency).
//   - Otherwise the port returns reg[addr].
// - Source-pending:
//   - src_p(x) = pending[x] && !(wb_we && wb_rd==x).
//   - A same-cycle writeback resolves the hazard.
//   - Register 0 is never pending.
// - Stall:
//   - stall = iss_valid && (src_p(rs_addr) || src_p(rt_addr) || (iss_we && src_p(iss_rd))).
//   - The iss_rd term blocks WAW on an in-flight destination.
// - Issue:
//   - If iss_valid && !stall && iss_we && iss_rd!=0, pending[iss_rd] is set at the posedge.
//   - Simultaneous set and clear of the same index: set wins, since the new producer is in flight.
// - No internal state machine beyond the scoreboard.
//   - One outstanding producer per register, guaranteed by the WAW stall.
//   - Pipeline latency is not assumed; any number of cycles may pass between issue and writeback.
// - A writeback to a non-pending register is legal and commits normally.
// TESTING
// - Reset:
//   - Stimulus: write reg5=0xDEADBEEF, then reset=0 for 1 cycle.
//   - Required: rs_addr=5 -> rs_data=0; pending=0; wb_count=0.
// - Commit/read:
//   - Stimulus: bundle {1,5'd3,32'h12345678}, next cycle bundle we=0.
//   - Required: rs_addr=3 -> rs_data=0x12345678; wb_count=1.
// - Bypass:
//   - Stimulus: bundle {1,5'd7,32'hA5A5A5A5}, rt_addr=7 in the same cycle.
//   - Required: rt_data=0xA5A5A5A5 before the edge.
// - R0:
//   - Stimulus: bundle {1,5'd0,32'hFFFFFFFF}.
//   - Required: rs_addr=0 -> 0; wb_count unchanged; pending[0]=0.
// - Hazard:
//   - Stimulus: issue we rd=4; next cycle issue rs=4.
//   - Required: stall=1 and pipe_ld=0 until bundle {1,4,x}; in that cycle stall=0.
// - Set/clear collision:
//   - Stimulus: pending[9]=1; same cycle wb rd=9 and issue we rd=9 (not stalled).
//   - Required: pending[9]=1 after the edge.
// - Counter wrap:
//   - Stimulus: CNT_W=4, 17 commits to reg1.
//   - Required: wb_count=1.

Source files
------------

// File: rtl/wb_regfile_scoreboard.sv
// rtl/wb_regfile_scoreboard.sv - writeback register bank with bypassed reads, pending scoreboard and issue stall
module wb_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BUND_W = 38,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUND_W-1:0]       wb_bundle,
    input  logic [ADDR_W-1:0]       rs_addr,
    input  logic [ADDR_W-1:0]       rt_addr,
    output logic [DATA_W-1:0]       rs_data,
    output logic [DATA_W-1:0]       rt_data,
    input  logic                    iss_valid,
    input  logic                    iss_we,
    input  logic [ADDR_W-1:0]       iss_rd,
    output logic                    stall,
    output logic                    pipe_ld,
    output logic [(2**ADDR_W)-1:0]  pending,
    output logic [CNT_W-1:0]        wb_count
);
    localparam int NREG = 2**ADDR_W;

    logic                wb_we;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_commit;

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [NREG-1:0]     pending_q;
    logic [NREG-1:0]     pending_d;
    logic [CNT_W-1:0]    wb_count_q;
    logic [CNT_W-1:0]    wb_count_d;

    logic                rs_p;
    logic                rt_p;
    logic                rd_p;
    logic                issue_set;

    assign wb_we     = wb_bundle[BUND_W-1];
    assign wb_rd     = wb_bundle[DATA_W +: ADDR_W];
    assign wb_data   = wb_bundle[DATA_W-1:0];
    // Writes to r0 are discarded entirely: no data, no count, no scoreboard effect.
    assign wb_commit = wb_we && (wb_rd != '0);

    // Read port A: r0 is hardwired zero, a same-cycle commit bypasses the bank.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_we && (wb_rd == rs_addr)) begin
            rs_data = wb_data;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_we && (wb_rd == rt_addr)) begin
            rt_data = wb_data;
        end
    end

    // A pending register whose producer is writing back this cycle is already resolved.
    assign rs_p = pending_q[rs_addr] && !(wb_we && (wb_rd == rs_addr));
    assign rt_p = pending_q[rt_addr] && !(wb_we && (wb_rd == rt_addr));
    assign rd_p = pending_q[iss_rd]  && !(wb_we && (wb_rd == iss_rd));

    // The destination term keeps at most one producer in flight per register (WAW).
    assign stall     = iss_valid && (rs_p || rt_p || (iss_we && rd_p));
    assign pipe_ld   = !stall;
    assign issue_set = iss_valid && !stall && iss_we && (iss_rd != '0);

    // Scoreboard next state: clear on commit first so a colliding issue leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (wb_commit) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (issue_set) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    // Retired-write counter, wraps naturally at its width.
    always_comb begin
        wb_count_d = wb_count_q;
        if (wb_commit) begin
            wb_count_d = wb_count_q + CNT_W'(1);
        end
    end

    // State registers; reset overrides any simultaneous commit or issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            wb_count_q <= '0;
        end else begin
            if (wb_commit) begin
                regs_q[wb_rd] <= wb_data;
            end
            pending_q  <= pending_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign pending  = pending_q;
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb/tb_wb_regfile_scoreboard.sv - vector table and scoreboard bench for wb_regfile_scoreboard
module tb_wb_regfile_scoreboard;

    typedef struct {
        logic        rstn;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iv;
        logic        iw;
        logic [4:0]  ird;
        logic [31:0] ers;
        logic [31:0] ert;
        logic        est;
        logic [31:0] epend;
        logic [3:0]  ecnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [37:0] wb_bundle;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        iss_valid;
    logic        iss_we;
    logic [4:0]  iss_rd;
    logic        stall;
    logic        pipe_ld;
    logic [31:0] pending;
    logic [3:0]  wb_count;

    int errors = 0;
    int checks = 0;
    vec_t expq[$];
    vec_t tbl[25];

    wb_regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BUND_W(38), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_bundle (wb_bundle),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rd    (iss_rd),
        .stall     (stall),
        .pipe_ld   (pipe_ld),
        .pending   (pending),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rstn, input logic we, input logic [4:0] rd,
                                input logic [31:0] data, input logic [4:0] rs, input logic [4:0] rt,
                                input logic iv, input logic iw, input logic [4:0] ird,
                                input logic [31:0] ers, input logic [31:0] ert, input logic est,
                                input logic [31:0] epend, input logic [3:0] ecnt);
        vec_t v;
        v.rstn = rstn; v.we = we; v.rd = rd; v.data = data;
        v.rs = rs; v.rt = rt; v.iv = iv; v.iw = iw; v.ird = ird;
        v.ers = ers; v.ert = ert; v.est = est; v.epend = epend; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare just before the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        reset     = v.rstn;
        wb_bundle = {v.we, v.rd, v.data};
        rs_addr   = v.rs;
        rt_addr   = v.rt;
        iss_valid = v.iv;
        iss_we    = v.iw;
        iss_rd    = v.ird;
        expq.push_back(v);
        #3;
        if (expq.size() == 0) begin
            check({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = expq.pop_front();
            check({tag, " rs_data"},  rs_data,          e.ers);
            check({tag, " rt_data"},  rt_data,          e.ert);
            check({tag, " stall"},    {31'd0, stall},   {31'd0, e.est});
            check({tag, " pipe_ld"},  {31'd0, pipe_ld}, {31'd0, !e.est});
            check({tag, " pending"},  pending,          e.epend);
            check({tag, " wb_count"}, {28'd0, wb_count}, {28'd0, e.ecnt});
        end
    endtask

    initial begin
        //               rstn we rd  data           rs  rt  iv iw ird  ers            ert            st pend          cnt
        tbl[0]  = mk(1, 1, 5,  32'hDEADBEEF, 5,  0,  0, 0, 0,  32'hDEADBEEF, 32'h0,        0, 32'h0,        4'd0);
        tbl[1]  = mk(0, 0, 0,  32'h0,        5,  5,  0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0,        4'd1);
        tbl[2]  = mk(1, 0, 0,  32'h0,        5,  0,  0, 0, 0,  32'h0,        32'h0,        0, 32'h0,        4'd0);
        tbl[3]  = mk(1, 1, 3,  32'h12345678, 3,  7,  0, 0, 0,  32'h12345678, 32'h0,        0, 32'h0,        4'd0);
        tbl[4]  = mk(1, 0, 0,  32'h0,        3,  0,  0, 0, 0,  32'h12345678, 32'h0,        0, 32'h0,        4'd1);
        tbl[5]  = mk(1, 1, 7,  32'hA5A5A5A5, 3,  7,  0, 0, 0,  32'h12345678, 32'hA5A5A5A5, 0, 32'h0,        4'd1);
        tbl[6]  = mk(1, 1, 0,  32'hFFFFFFFF, 0,  7,  0, 0, 0,  32'h0,        32'hA5A5A5A5, 0, 32'h0,        4'd2);
        tbl[7]  = mk(1, 0, 0,  32'h0,        0,  0,  0, 0, 0,  32'h0,        32'h0,        0, 32'h0,        4'd2);
        tbl[8]  = mk(1, 0, 0,  32'h0,        0,  0,  1, 1, 4,  32'h0,        32'h0,        0, 32'h0,        4'd2);
        tbl[9]  = mk(1, 0, 0,  32'h0,        4,  0,  1, 0, 0,  32'h0,        32'h0,        1, 32'h10,       4'd2);
        tbl[10] = mk(1, 0, 0,  32'h0,        4,  0,  1, 0, 0,  32'h0,        32'h0,        1, 32'h10,       4'd2);
        tbl[11] = mk(1, 1, 4,  32'h00004444, 4,  0,  1, 0, 0,  32'h00004444, 32'h0,        0, 32'h10,       4'd2);
        tbl[12] = mk(1, 0, 0,  32'h0,        4,  0,  0, 0, 0,  32'h00004444, 32'h0,        0, 32'h0,        4'd3);
        tbl[13] = mk(1, 0, 0,  32'h0,        0,  0,  1, 1, 9,  32'h0,        32'h0,        0, 32'h0,        4'd3);
        tbl[14] = mk(1, 0, 0,  32'h0,        0,  0,  1, 1, 9,  32'h0,        32'h0,        1, 32'h200,      4'd3);
        tbl[15] = mk(1, 1, 9,  32'h99999999, 9,  0,  1, 1, 9,  32'h99999999, 32'h0,        0, 32'h200,      4'd3);
        tbl[16] = mk(1, 0, 0,  32'h0,        9,  0,  0, 0, 0,  32'h99999999, 32'h0,        0, 32'h200,      4'd4);
        tbl[17] = mk(1, 1, 2,  32'h00000022, 9,  0,  1, 0, 0,  32'h99999999, 32'h0,        1, 32'h200,      4'd4);
        tbl[18] = mk(1, 1, 9,  32'h0000009A, 2,  9,  1, 0, 0,  32'h00000022, 32'h0000009A, 0, 32'h200,      4'd5);
        tbl[19] = mk(1, 0, 0,  32'h0,        0,  9,  0, 0, 0,  32'h0,        32'h0000009A, 0, 32'h0,        4'd6);
        tbl[20] = mk(1, 0, 0,  32'h0,        0,  0,  1, 1, 12, 32'h0,        32'h0,        0, 32'h0,        4'd6);
        tbl[21] = mk(1, 0, 0,  32'h0,        0,  0,  1, 0, 12, 32'h0,        32'h0,        0, 32'h1000,     4'd6);
        tbl[22] = mk(1, 0, 0,  32'h0,        12, 0,  0, 0, 0,  32'h0,        32'h0,        0, 32'h1000,     4'd6);
        tbl[23] = mk(0, 1, 12, 32'h0000CCCC, 12, 0,  1, 1, 13, 32'h0000CCCC, 32'h0,        0, 32'h1000,     4'd6);
        tbl[24] = mk(1, 0, 0,  32'h0,        12, 0,  0, 0, 0,  32'h0,        32'h0,        0, 32'h0,        4'd0);

        reset = 1'b0; wb_bundle = '0; rs_addr = '0; rt_addr = '0;
        iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Counter wrap: 17 commits to r1 on a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            step(mk(1, 1, 1, 32'(i + 1), 1, 0, 0, 0, 0, 32'(i + 1), 32'h0, 0, 32'h0, 4'(i % 16)),
                 $sformatf("wrap%0d", i));
        end
        step(mk(1, 0, 0, 32'h0, 1, 1, 0, 0, 0, 32'd17, 32'd17, 0, 32'h0, 4'd1), "wrap_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
